// File: rtl/mandel_pixel_scheduler.sv
// rtl/mandel_pixel_scheduler.sv - raster pixel scheduler feeding the depth calculator
// Walks a frame pixel by pixel, issues one calculation per pixel and streams its depth out.
module mandel_pixel_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int FRAC   = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [31:0] re_origin,
  input  logic [31:0] im_origin,
  input  logic [31:0] step,
  output logic        calc_start,
  output logic [9:0]  calc_x,
  output logic [8:0]  calc_y,
  output logic [31:0] calc_re_c,
  output logic [31:0] calc_im_c,
  input  logic        calc_done,
  input  logic [7:0]  calc_depth,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        busy,
  output logic        frame_done
);

  if (WIDTH < 1 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 512 || FRAC < 0 || FRAC > 31) begin : g_bad_params
    $error("mandel_pixel_scheduler: parameter out of range");
  end

  localparam logic [9:0] x_last = 10'(WIDTH - 1);
  localparam logic [8:0] y_last = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_issue,
    s_wait,
    s_output
  } state_t;

  state_t      state;
  logic [31:0] re_org;
  logic [31:0] step_q;
  logic        done_q;

  assign busy = (state != s_idle);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= s_idle;
      re_org     <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      calc_start <= 1'b0;
      calc_x     <= '0;
      calc_y     <= '0;
      calc_re_c  <= '0;
      calc_im_c  <= '0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tuser    <= 1'b0;
      m_tlast    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      done_q     <= calc_done;
      calc_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        s_idle: begin
          if (frame_start) begin
            re_org     <= re_origin;
            step_q     <= step;
            calc_x     <= '0;
            calc_y     <= '0;
            calc_re_c  <= re_origin;
            calc_im_c  <= im_origin;
            calc_start <= 1'b1;
            state      <= s_issue;
          end
        end
        s_issue: begin
          state <= s_wait;
        end
        s_wait: begin
          // a done level left over from the previous pixel must not complete this one
          if (calc_done && !done_q) begin
            m_tdata  <= calc_depth;
            m_tuser  <= (calc_x == '0) && (calc_y == '0);
            m_tlast  <= (calc_x == x_last);
            m_tvalid <= 1'b1;
            state    <= s_output;
          end
        end
        s_output: begin
          if (m_tvalid) begin
            if (m_tready) begin
              m_tvalid <= 1'b0;
              if (calc_x != x_last) begin
                calc_x    <= calc_x + 10'd1;
                calc_re_c <= calc_re_c + step_q;
              end else begin
                calc_x    <= '0;
                calc_re_c <= re_org;
                calc_y    <= calc_y + 9'd1;
                calc_im_c <= calc_im_c - step_q;
              end
              if (calc_x == x_last && calc_y == y_last) begin
                frame_done <= 1'b1;
              end else begin
                calc_start <= 1'b1;
                state      <= s_issue;
              end
            end
          end else begin
            // frame_done cycle: still busy, so a frame_start here is not taken
            state <= s_idle;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb/tb_mandel_pixel_scheduler.sv - directed self-checking bench for mandel_pixel_scheduler
module tb_mandel_pixel_scheduler;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [31:0] re_origin;
  logic [31:0] im_origin;
  logic [31:0] step;
  logic        calc_start;
  logic [9:0]  calc_x;
  logic [8:0]  calc_y;
  logic [31:0] calc_re_c;
  logic [31:0] calc_im_c;
  logic        calc_done;
  logic [7:0]  calc_depth;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic        busy;
  logic        frame_done;

  mandel_pixel_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC(16)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
    .re_origin(re_origin), .im_origin(im_origin), .step(step),
    .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
    .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
    .calc_done(calc_done), .calc_depth(calc_depth),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .busy(busy), .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int tests    = 0;
  int failures = 0;

  int  calc_delay = 3;
  bit  stale_mode = 1'b0;
  int  sx, sy;

  // Depth calculator: depth = x + 4*y, done raised calc_delay cycles after start.
  // In stale mode done stays high from the previous pixel, drops, and re-rises 5 cycles after start.
  initial begin
    calc_done  = 1'b0;
    calc_depth = 8'd0;
    forever begin
      @(negedge sysclk);
      if (calc_start === 1'b1) begin
        sx = int'(calc_x);
        sy = int'(calc_y);
        if (stale_mode) begin
          repeat (2) @(negedge sysclk);
          calc_done = 1'b0;
          repeat (3) @(negedge sysclk);
        end else begin
          calc_done = 1'b0;
          repeat (calc_delay) @(negedge sysclk);
        end
        calc_depth = 8'(sx + 4 * sy);
        calc_done  = 1'b1;
      end
    end
  end

  logic [9:0]  beats[$];
  int          start_count  = 0;
  int          start_double = 0;
  int          coord_err    = 0;
  int          done_count   = 0;
  logic        prev_start   = 1'b0;
  logic [31:0] pix21_re     = '0;
  logic [31:0] pix21_im     = '0;
  logic [31:0] exp_re_org   = '0;
  logic [31:0] exp_im_org   = '0;
  logic [31:0] exp_step     = '0;

  initial begin
    forever begin
      @(negedge sysclk);
      if (calc_start === 1'b1) begin
        start_count++;
        if (prev_start === 1'b1) start_double++;
        if (calc_re_c !== exp_re_org + 32'(calc_x) * exp_step ||
            calc_im_c !== exp_im_org - 32'(calc_y) * exp_step) coord_err++;
        if (calc_x == 10'd2 && calc_y == 9'd1) begin
          pix21_re = calc_re_c;
          pix21_im = calc_im_c;
        end
      end
      prev_start = calc_start;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) beats.push_back({m_tuser, m_tlast, m_tdata});
      if (frame_done === 1'b1) done_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st);
    re_origin   = re;
    im_origin   = im;
    step        = st;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic set_expect(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st);
    exp_re_org = re;
    exp_im_org = im;
    exp_step   = st;
  endtask

  task automatic clear_counts();
    beats.delete();
    start_count  = 0;
    start_double = 0;
    coord_err    = 0;
  endtask

  task automatic wait_frame_done(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("%s frame_done_seen", tag), 32'(frame_done), 32'd1);
  endtask

  task automatic wait_start_at(input logic [9:0] wx, input logic [8:0] wy, input string tag);
    int n = 0;
    while (!(calc_start === 1'b1 && calc_x == wx && calc_y == wy) && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("%s start_seen", tag), 32'(calc_start === 1'b1 && calc_x == wx && calc_y == wy), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check($sformatf("%s beat_count", tag), 32'(beats.size()), 32'(NPIX));
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      check($sformatf("%s beat%0d data", tag, i), 32'(beats[i][7:0]), 32'(i));
      check($sformatf("%s beat%0d tuser", tag, i), 32'(beats[i][9]), 32'(i == 0));
      check($sformatf("%s beat%0d tlast", tag, i), 32'(beats[i][8]), 32'(i % WIDTH == WIDTH - 1));
    end
    check($sformatf("%s start_pulses", tag), 32'(start_count), 32'(NPIX));
    check($sformatf("%s start_wide", tag), 32'(start_double), 32'd0);
    check($sformatf("%s coord_errors", tag), 32'(coord_err), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s calc_start", tag), 32'(calc_start), 32'd0);
    check($sformatf("%s calc_x", tag), 32'(calc_x), 32'd0);
    check($sformatf("%s calc_y", tag), 32'(calc_y), 32'd0);
    check($sformatf("%s calc_re_c", tag), calc_re_c, 32'd0);
    check($sformatf("%s calc_im_c", tag), calc_im_c, 32'd0);
    check($sformatf("%s m_tdata", tag), 32'(m_tdata), 32'd0);
    check($sformatf("%s m_tvalid", tag), 32'(m_tvalid), 32'd0);
    check($sformatf("%s m_tuser", tag), 32'(m_tuser), 32'd0);
    check($sformatf("%s m_tlast", tag), 32'(m_tlast), 32'd0);
    check($sformatf("%s frame_done", tag), 32'(frame_done), 32'd0);
  endtask

  initial begin
    bit stable_ok;
    int n;
    reset       = 1'b1;
    frame_start = 1'b0;
    m_tready    = 1'b1;
    re_origin   = '0;
    im_origin   = '0;
    step        = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Frame A: nominal frame
    calc_delay = 3;
    set_expect(32'hFFFE0000, 32'h00010000, 32'h00004000);
    clear_counts();
    done_count = 0;
    pulse_start(32'hFFFE0000, 32'h00010000, 32'h00004000);
    wait_frame_done("A");
    check("A busy_in_done_cycle", 32'(busy), 32'd1);
    tick();
    check("A frame_done_width", 32'(frame_done), 32'd0);
    check("A busy_after", 32'(busy), 32'd0);
    check_frame("A");
    check("A pix21_re", pix21_re, 32'hFFFE8000);
    check("A pix21_im", pix21_im, 32'h0000C000);
    check("A done_pulses", 32'(done_count), 32'd1);

    // Frame B: stale done level, backpressure on beat 5, ignored frame_start pulses
    stale_mode = 1'b1;
    set_expect(32'h10000000, 32'hF0000000, 32'h00000100);
    clear_counts();
    pulse_start(32'h10000000, 32'hF0000000, 32'h00000100);
    tick();
    tick();
    pulse_start(32'hDEAD0000, 32'hBEEF0000, 32'h12345678);
    wait_start_at(10'd1, 9'd1, "B pix5");
    m_tready = 1'b0;
    n = 0;
    while (m_tvalid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("B beat5_valid_seen", 32'(m_tvalid), 32'd1);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_tvalid !== 1'b1 || m_tdata !== 8'd5 || m_tuser !== 1'b0 ||
          m_tlast !== 1'b0 || calc_start !== 1'b0) stable_ok = 1'b0;
      frame_start = (i == 3);
      tick();
    end
    frame_start = 1'b0;
    check("B backpressure_stable", 32'(stable_ok), 32'd1);
    m_tready = 1'b1;
    wait_frame_done("B");
    check_frame("B");
    check("B busy_in_done_cycle", 32'(busy), 32'd1);
    re_origin   = 32'h55550000;
    im_origin   = 32'h66660000;
    step        = 32'h00000001;
    frame_start = 1'b1;
    tick();
    check("B start_in_done_cycle_ignored", 32'(busy), 32'd0);
    check("B done_pulses", 32'(done_count), 32'd2);

    // Frame C: frame_start in the first IDLE cycle, with re/im wrapping past 2^31
    stale_mode = 1'b0;
    calc_delay = 1;
    set_expect(32'h7FFFC000, 32'h80002000, 32'h00002000);
    clear_counts();
    re_origin = 32'h7FFFC000;
    im_origin = 32'h80002000;
    step      = 32'h00002000;
    tick();
    frame_start = 1'b0;
    check("C busy", 32'(busy), 32'd1);
    check("C calc_start", 32'(calc_start), 32'd1);
    check("C latched_re", calc_re_c, 32'h7FFFC000);
    check("C latched_im", calc_im_c, 32'h80002000);
    wait_frame_done("C");
    tick();
    check_frame("C");
    check("C busy_after", 32'(busy), 32'd0);

    // Frame D: reset while waiting on pixel 6
    calc_delay = 4;
    set_expect(32'hFFFE0000, 32'h00010000, 32'h00004000);
    clear_counts();
    pulse_start(32'hFFFE0000, 32'h00010000, 32'h00004000);
    wait_start_at(10'd2, 9'd1, "D pix6");
    tick();
    reset = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    repeat (10) tick();
    reset = 1'b0;
    tick();

    // Frame E: restarts cleanly at (0,0)
    calc_delay = 2;
    clear_counts();
    pulse_start(32'hFFFE0000, 32'h00010000, 32'h00004000);
    wait_frame_done("E");
    tick();
    check_frame("E");
    check("E busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
- Upstream stage of depth_calculator.
- Walks every pixel of a frame in raster order and maps (x,y) to complex c in Q(32-FRAC).FRAC using an origin and a step.
- Issues one start per pixel to the depth calculator and waits for its done.
- Forwards each final_depth on a valid/ready pixel stream, with start-of-frame and end-of-line markers, toward the colour mapper / video buffer.

Parameters:
- WIDTH, 640, pixels per line (x range 0..WIDTH-1, at most 1024)
- HEIGHT, 480, lines per frame (y range 0..HEIGHT-1, at most 512)
- FRAC, 16, fractional bits of re/im words; informational only, arithmetic is plain 32-bit two's complement

Ports:
- sysclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE
- re_origin  in  32  signed re of pixel (0,0)
- im_origin  in  32  signed im of pixel (0,0)
- step  in  32  signed distance per pixel, same for x and y
- calc_start  out  1  one-cycle start pulse to depth calculator
- calc_x  out  10  current x
- calc_y  out  9  current y
- calc_re_c  out  32  re of c for current pixel
- calc_im_c  out  32  im of c for current pixel
- calc_done  in  1  depth calculator done (level; stays high until next start)
- calc_depth  in  8  depth calculator final_depth, valid while calc_done=1
- m_tdata  out  8  pixel depth
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tuser  out  1  high on pixel (0,0) beat
- m_tlast  out  1  high on x=WIDTH-1 beat
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: all outputs, counters, latched origin/step and done_q go to 0; state IDLE. Applies immediately, including mid-frame; an in-flight pixel is discarded.
- States: IDLE, ISSUE, WAIT, OUTPUT.

IDLE:
- On frame_start: latch re_origin, im_origin and step.
- Set x=0, y=0, calc_re_c=re_origin, calc_im_c=im_origin.
- Go to ISSUE.

ISSUE:
- calc_start=1 for exactly this cycle; calc_x/y/re_c/im_c are stable.
- Go to WAIT next cycle.

WAIT:
- done_q is a register of calc_done, updated every cycle.
- A done edge is calc_done=1 and done_q=0. Only a done edge completes the pixel; a level still high from the previous pixel is ignored.
- On a done edge: m_tdata<=calc_depth, m_tuser<=(x==0 && y==0), m_tlast<=(x==WIDTH-1), m_tvalid<=1. Go to OUTPUT.
- No timeout.

OUTPUT:
- m_tvalid, m_tdata, m_tuser and m_tlast hold until m_tready=1.
- On the handshake (m_tvalid && m_tready), m_tvalid<=0 and the pixel advances:
  - If x<WIDTH-1: x+1, calc_re_c+=step.
  - Else: x=0, calc_re_c=latched re_origin, y+1, calc_im_c-=step (y grows downward, im decreases).
  - If the accepted beat was (WIDTH-1, HEIGHT-1): frame_done=1 for one cycle, go to IDLE. Otherwise go to ISSUE.
- Throughput: at least 2 cycles of scheduler overhead per pixel, plus calculator latency, plus backpressure.

Other rules:
- Arithmetic: incremental add/subtract modulo 2^32, no saturation. Result is bit-exact with origin + x*step and origin - y*step modulo 2^32.
- calc_x/y/re_c/im_c change only on a handshake or when leaving IDLE.
- frame_start while busy=1 is ignored. Origin and step changes while busy have no effect until the next frame.
- frame_start in the same cycle as a frame_done pulse is ignored, because the state is still OUTPUT. frame_start in the first IDLE cycle is honoured.
- m_tready high when m_tvalid is low has no effect.

Test Plan:
- Setup for all scenarios: WIDTH=4, HEIGHT=3, behavioural calculator model with a configurable delay and depth=x+4*y.
- Reset, then frame_start with re_origin=0xFFFE0000, im_origin=0x00010000, step=0x00004000 -> 12 beats m_tdata=0..11; m_tuser only on beat 0; m_tlast on beats 3, 7, 11; one frame_done after beat 11; then IDLE with busy=0.
- Same frame, check at pixel (2,1) -> calc_re_c=0xFFFE8000, calc_im_c=0x0000C000; calc_start one cycle wide per pixel, 12 pulses total.
- Calculator holds done high from the previous pixel and raises it again 5 cycles after start -> the scheduler waits for the new edge; no duplicate or stale beats.
- m_tready low for 10 cycles on beat 5 -> m_tdata, m_tlast and m_tuser are stable and calc_start is not pulsed until the handshake; the stream order is unchanged.
- Extra frame_start pulses during the frame and in the frame_done cycle -> ignored; a frame_start one cycle later starts a new frame with newly latched origin/step.
- reset asserted during WAIT at pixel 6 -> all outputs 0 within the reset; the next frame_start restarts at (0,0) with no leftover beat.
